// File: rtl/mips_cpu_instr_memory.sv
// mips_cpu_instr_memory: loadable instruction store for a MIPS CPU.
// A streaming loader fills words from index 0. The block then serves
// single-cycle combinational fetches relative to BASE_ADDR.
// Optional macro INSTR_MEM_BYTESWAP_EN: byte-reverses fetched words for a
// CPU whose fetch port expects reversed byte order.
module mips_cpu_instr_memory #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        fetch_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   wr_ptr_r;
    logic               fetch_error_r;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               transfer_s;
    logic               last_slot_s;
    logic [31:0]        offset_s;
    logic               in_range_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic [31:0]        read_word_s;

    // Presents a stored word in the byte order the CPU fetch port expects.
    function automatic logic [31:0] fetch_view(input logic [31:0] w);
`ifdef INSTR_MEM_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // The pointer only ever reaches DEPTH_WORDS, so it doubles as word_count.
    assign load_ready  = (state_r != ST_READY);
    assign load_done   = (state_r == ST_READY);
    assign fetch_error = fetch_error_r;
    assign transfer_s  = load_valid & load_ready & clk_enable;
    assign last_slot_s = (wr_ptr_r == CNT_W'(DEPTH_WORDS - 1));

    // Next-state logic: a final-word or last-slot transfer moves to READY once.
    always_comb begin
        state_next_s = state_r;
        if (transfer_s) begin
            if (load_last || last_slot_s) begin
                state_next_s = ST_READY;
            end else begin
                state_next_s = ST_LOADING;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State and write pointer; reset aborts any load in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_EMPTY;
            wr_ptr_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (transfer_s) begin
                wr_ptr_r <= wr_ptr_r + CNT_W'(1);
            end
        end
    end

    // Program storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (transfer_s) begin
            mem[wr_ptr_r[IDX_W-1:0]] <= load_data;
        end
    end

    // Address decode: aligned, at/above base, and below the loaded word count.
    always_comb begin
        offset_s   = instr_address - BASE_ADDR;
        rd_idx_s   = offset_s[IDX_W+1:2];
        in_range_s = 1'b0;
        if ((instr_address[1:0] == 2'b00) && (instr_address >= BASE_ADDR) &&
            ((offset_s >> 2) < 32'(wr_ptr_r))) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
    end

    assign read_word_s = mem[rd_idx_s];

    // Fetch data path: NOP unless loaded and in range.
    always_comb begin
        instr_readdata = 32'h00000000;
        if ((state_r == ST_READY) && in_range_s) begin
            instr_readdata = fetch_view(read_word_s);
        end else begin
            instr_readdata = 32'h00000000;
        end
    end

    // Sticky illegal-fetch flag; address 0 is the halt address and is legal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_error_r <= 1'b0;
        end else if (clk_enable && (state_r == ST_READY) &&
                     (instr_address != 32'h00000000) && !in_range_s) begin
            fetch_error_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed testbench for mips_cpu_instr_memory (default parameters).
module tb_mips_cpu_instr_memory;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        fetch_error;

    int passed;
    int total;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } fvec_t;

    fvec_t       ftab [8];
    logic [31:0] prog [5];

    mips_cpu_instr_memory dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_done      (load_done),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .fetch_error    (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef INSTR_MEM_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Called at a falling edge; the transfer happens on the following rising edge.
    task automatic load_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        instr_address = 32'h00000000;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b0; clk_enable = 1'b1; load_valid = 1'b0;
        load_data = 32'h0; load_last = 1'b0; instr_address = 32'hBFC00000;

        prog[0] = 32'h0FF00003; prog[1] = 32'h24420020; prog[2] = 32'h24420001;
        prog[3] = 32'h00000008; prog[4] = 32'h24000000;

        ftab[0] = '{32'hBFC00000, exp_w(32'h0FF00003), 1'b0};
        ftab[1] = '{32'hBFC00004, exp_w(32'h24420020), 1'b0};
        ftab[2] = '{32'hBFC00008, exp_w(32'h24420001), 1'b0};
        ftab[3] = '{32'hBFC0000C, exp_w(32'h00000008), 1'b0};
        ftab[4] = '{32'hBFC00010, exp_w(32'h24000000), 1'b0};
        ftab[5] = '{32'h00000000, 32'h00000000,        1'b0};
        ftab[6] = '{32'hBFC00014, 32'h00000000,        1'b1};
        ftab[7] = '{32'hBFC00000, exp_w(32'h0FF00003), 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(fetch_error), 32'd0);
        chk("rst_rdata", instr_readdata, 32'h0);
        reset = 1'b1;
        instr_address = 32'h0;

        // clk_enable=0 blocks a transfer, even one flagged last
        clk_enable = 1'b0;
        load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0; clk_enable = 1'b1;
        chk("ce0_done", 32'(load_done), 32'd0);
        chk("ce0_ready", 32'(load_ready), 32'd1);

        // Five-word program, last on the fifth
        for (int i = 0; i < 5; i++) begin
            load_word(prog[i], (i == 4));
            if (i == 3) chk("prog_done_early", 32'(load_done), 32'd0);
        end
        chk("prog_done", 32'(load_done), 32'd1);
        chk("prog_ready", 32'(load_ready), 32'd0);

        // Fetch table: data same cycle, error after the next edge
        for (int i = 0; i < 8; i++) begin
            instr_address = ftab[i].addr;
            #1;
            chk($sformatf("fetch%0d_rdata", i), instr_readdata, ftab[i].rdata);
            @(negedge clk);
            chk($sformatf("fetch%0d_err", i), 32'(fetch_error), 32'(ftab[i].err));
        end

        // Loader is ignored in READY
        instr_address = 32'h0;
        load_word(32'h11111111, 1'b1);
        instr_address = 32'hBFC00000; #1;
        chk("ready_nowrite", instr_readdata, exp_w(32'h0FF00003));
        instr_address = 32'hBFC00014; #1;
        chk("ready_nocount", instr_readdata, 32'h0);

        // Reset mid-load, then reload from word 0
        reset_pulse();
        chk("rst2_err", 32'(fetch_error), 32'd0);
        for (int i = 0; i < 3; i++) load_word(32'hA0000000 + 32'(i), 1'b0);
        chk("mid_done", 32'(load_done), 32'd0);
        chk("mid_ready", 32'(load_ready), 32'd1);
        instr_address = 32'hBFC00000; #1;
        chk("loading_rdata", instr_readdata, 32'h0);
        #1 reset = 1'b0;
        #1;
        chk("abort_done", 32'(load_done), 32'd0);
        chk("abort_ready", 32'(load_ready), 32'd1);
        chk("abort_rdata", instr_readdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        instr_address = 32'h0;
        load_word(32'h24020005, 1'b1);
        chk("reload_done", 32'(load_done), 32'd1);
        @(negedge clk);
        chk("halt_err", 32'(fetch_error), 32'd0);
        instr_address = 32'hBFC00000; #1;
        chk("reload_rdata", instr_readdata, exp_w(32'h24020005));
        @(negedge clk);
        chk("reload_err", 32'(fetch_error), 32'd0);

        // Misaligned fetch: held off by clk_enable, then flagged
        clk_enable = 1'b0;
        instr_address = 32'hBFC00002; #1;
        chk("misalign_rdata", instr_readdata, 32'h0);
        @(negedge clk);
        chk("misalign_ce0_err", 32'(fetch_error), 32'd0);
        clk_enable = 1'b1;
        @(negedge clk);
        chk("misalign_err", 32'(fetch_error), 32'd1);
        instr_address = 32'hBFC00004; #1;
        chk("stale_word_hidden", instr_readdata, 32'h0);

        // Below-base fetch after a fresh reset
        reset_pulse();
        load_word(32'h12345678, 1'b1);
        instr_address = 32'hBFBFFFFC; #1;
        chk("below_rdata", instr_readdata, 32'h0);
        @(negedge clk);
        chk("below_err", 32'(fetch_error), 32'd1);

        // Fill to depth without load_last
        reset_pulse();
        for (int i = 0; i < 64; i++) begin
            load_word(32'h10000000 + 32'(i), 1'b0);
            if (i == 62) chk("fill63_done", 32'(load_done), 32'd0);
        end
        chk("fill_done", 32'(load_done), 32'd1);
        chk("fill_ready", 32'(load_ready), 32'd0);
        load_word(32'hFFFFFFFF, 1'b0);
        instr_address = 32'hBFC00000; #1;
        chk("fill_w0", instr_readdata, exp_w(32'h10000000));
        instr_address = 32'hBFC000FC; #1;
        chk("fill_w63", instr_readdata, exp_w(32'h1000003F));
        @(negedge clk);
        chk("fill_w63_err", 32'(fetch_error), 32'd0);
        instr_address = 32'hBFC00100; #1;
        chk("fill_past_rdata", instr_readdata, 32'h0);
        @(negedge clk);
        chk("fill_past_err", 32'(fetch_error), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_cpu_instr_memory.md
MIPS_CPU_INSTR_MEMORY -- requirements
Module: mips_cpu_instr_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: instruction storage depth in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'hBFC00000: byte address of word 0 (reset vector).
REQ-003 The block SHALL provide these ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_enable  input  1  when 0, loader state, pointer and error flag hold.
- load_valid  input  1  loader word valid.
- load_data  input  32  program word, MIPS big-endian word value.
- load_last  input  1  qualifies load_valid: final program word.
- load_ready  output  1  block accepts a loader word this cycle.
- load_done  output  1  program loaded; fetch port live.
- instr_address  input  32  CPU fetch byte address.
- instr_readdata  output  32  fetched instruction, same cycle.
- fetch_error  output  1  sticky illegal-fetch flag.

Function
REQ-004 FSM states SHALL be EMPTY, LOADING and READY.
REQ-005 A word transfer SHALL occur on a rising edge with load_valid=1, load_ready=1 and clk_enable=1; load_data is written to word[wr_ptr] and wr_ptr increments by 1.
REQ-006 load_ready SHALL be 1 in EMPTY and LOADING and 0 in READY; load_done SHALL be 1 only in READY.
REQ-007 Transitions: EMPTY->LOADING on a transfer without load_last; EMPTY or LOADING->READY on a transfer with load_last=1 or on the transfer into word DEPTH_WORDS-1; otherwise the state holds.
REQ-008 In READY, load_valid SHALL be ignored, with no write and no pointer change.
REQ-009 word_count SHALL equal the number of words accepted, saturating at DEPTH_WORDS.
REQ-010 Fetch SHALL be combinational, with zero-cycle latency from instr_address to instr_readdata.
REQ-011 A fetch is in range when instr_address[1:0]=0 and BASE_ADDR <= instr_address < BASE_ADDR+4*word_count; index = (instr_address-BASE_ADDR)>>2, with 32-bit unsigned subtraction and no wrap-around match.
REQ-012 instr_readdata SHALL be the stored word when the state is READY and the fetch is in range; otherwise it SHALL be 32'h00000000 (NOP).
REQ-013 fetch_error SHALL be set on a rising edge in READY with clk_enable=1 when instr_address is nonzero and out of range (misaligned, below base, or at/after word_count).
REQ-014 instr_address=0 is the CPU halt address; it SHALL return 0 and SHALL NOT set fetch_error.
REQ-015 fetch_error SHALL be cleared only by reset.
REQ-016 A simultaneous load_last and final-depth transfer SHALL yield a single move to READY.

Reset
REQ-017 reset low SHALL immediately force: state EMPTY, wr_ptr=0, word_count=0, fetch_error=0, load_ready=1, load_done=0, instr_readdata=0.
REQ-018 Storage contents SHALL NOT be reset; after reset, reads return 0 because word_count=0.
REQ-019 A reset asserted mid-load SHALL abort the load; the next program SHALL load from word 0.

Configuration
REQ-020 Macro INSTR_MEM_BYTESWAP_EN: when defined, instr_readdata SHALL be {w[7:0],w[15:8],w[23:16],w[31:24]} of the stored word w, matching the CPU's byte-reversed fetch port; when undefined, instr_readdata SHALL equal w unchanged.
REQ-021 Zero and NOP outputs SHALL be unaffected by INSTR_MEM_BYTESWAP_EN.

Verification
REQ-022 Load 0x0FF00003, 0x24420020, 0x24420001, 0x00000008, and 0x24000000 with load_last on the fifth word -> load_done=1 on the next cycle; fetch 0xBFC00000 -> 0x0300F00F with the macro, 0x0FF00003 without it.
REQ-023 After the REQ-022 load, fetch 0xBFC00014 -> instr_readdata=0 and fetch_error=1 after the next edge; fetch 0x00000000 on a fresh load -> fetch_error stays 0.
REQ-024 Stream 64 words without load_last (DEPTH_WORDS=64) -> READY after the 64th transfer, load_ready=0, and a 65th word is not written.
REQ-025 Hold clk_enable=0 during a load_valid pulse -> wr_ptr unchanged and word not written; with clk_enable=1 the word is accepted.
REQ-026 Assert reset low after 3 loaded words -> load_done=0 and fetch 0xBFC00000 reads 0 immediately; a reload of 0x24020005 then fetches correctly.
REQ-027 Fetch 0xBFC00002 in READY -> instr_readdata=0 and fetch_error=1.
